tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_tick_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Shared 1 kHz prescaler driving N_CH programmable periodic/one-shot tick channels.
// Optional square-wave outputs are built when TICK_SCHED_SQUARE_EN is defined.
module tick_scheduler #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned PW       = 16
) (
    input  logic                    clk_fpga,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [PW-1:0]           cfg_period,
    input  logic                    cfg_oneshot,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         tick_out,
    output logic                    base_tick,
    output logic [N_CH-1:0]         sq_out
);

    localparam int unsigned CW  = $clog2(N_CH);
    localparam int unsigned PSW = $clog2(PRESCALE);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    logic [PSW-1:0]  r_presc;
    logic            r_base_tick;

    state_t          r_state    [N_CH];
    state_t          w_state_nx [N_CH];
    logic [PW-1:0]   r_period    [N_CH];
    logic [PW-1:0]   w_period_nx [N_CH];
    logic [PW-1:0]   r_cnt    [N_CH];
    logic [PW-1:0]   w_cnt_nx [N_CH];
    logic [N_CH-1:0] r_oneshot;
    logic [N_CH-1:0] w_oneshot_nx;
    logic [N_CH-1:0] r_tick;
    logic [N_CH-1:0] w_tick_nx;
    logic [N_CH-1:0] w_cfg_hit;

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_base_tick <= 1'b0;
        end else begin
            if (r_presc == PSW'(PRESCALE - 1)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PSW'(1);
            end
            r_base_tick <= (r_presc == PSW'(PRESCALE - 1));
        end
    end

    assign base_tick = r_base_tick;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_cfg_hit[i] = cfg_we && (cfg_ch == CW'(i));
        end
    end

    // Priority per channel: stop, then start (seeing this cycle's write), then
    // a write to a running channel, then base-tick countdown.
    always_comb begin
        w_tick_nx = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_state_nx[i]   = r_state[i];
            w_period_nx[i]  = w_cfg_hit[i] ? cfg_period  : r_period[i];
            w_oneshot_nx[i] = w_cfg_hit[i] ? cfg_oneshot : r_oneshot[i];
            w_cnt_nx[i]     = r_cnt[i];
            if (stop[i]) begin
                w_state_nx[i] = ST_IDLE;
            end else if (start[i]) begin
                if (w_period_nx[i] != '0) begin
                    w_state_nx[i] = ST_RUN;
                    w_cnt_nx[i]   = w_period_nx[i];
                end else begin
                    w_state_nx[i] = ST_IDLE;
                end
            end else if (r_state[i] == ST_RUN) begin
                if (w_cfg_hit[i]) begin
                    if (w_period_nx[i] == '0) begin
                        w_state_nx[i] = ST_IDLE;
                    end else begin
                        w_cnt_nx[i] = w_period_nx[i];
                    end
                end else if (r_base_tick) begin
                    if (r_cnt[i] == PW'(1)) begin
                        w_tick_nx[i] = 1'b1;
                        if (r_oneshot[i]) begin
                            w_state_nx[i] = ST_IDLE;
                        end else begin
                            w_cnt_nx[i] = r_period[i];
                        end
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i]  <= ST_IDLE;
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_oneshot <= '0;
            r_tick    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i]  <= w_state_nx[i];
                r_period[i] <= w_period_nx[i];
                r_cnt[i]    <= w_cnt_nx[i];
            end
            r_oneshot <= w_oneshot_nx;
            r_tick    <= w_tick_nx;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            busy[i] = (r_state[i] == ST_RUN);
        end
    end

    assign tick_out = r_tick;

`ifdef TICK_SCHED_SQUARE_EN
    logic [N_CH-1:0] r_sq;
    logic [N_CH-1:0] w_sq_nx;

    // Leaving RUN clears the square wave even when a one-shot tick toggles it.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_sq_nx[i] = (w_state_nx[i] == ST_IDLE) ? 1'b0 : (r_sq[i] ^ w_tick_nx[i]);
        end
    end

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= '0;
        end else begin
            r_sq <= w_sq_nx;
        end
    end

    assign sq_out = r_sq;
`else
    assign sq_out = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Randomised bench for tick_scheduler against an edge-deadline reference model.
// Square-wave expectations follow TICK_SCHED_SQUARE_EN.
module tb_tick_scheduler;

    localparam int P  = 4;
    localparam int N  = 4;
    localparam int PW = 16;

    logic          clk_fpga = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          cfg_oneshot;
    logic [N-1:0]  start;
    logic [N-1:0]  stop;
    logic [N-1:0]  busy;
    logic [N-1:0]  tick_out;
    logic          base_tick;
    logic [N-1:0]  sq_out;

    tick_scheduler #(.PRESCALE(P), .N_CH(N), .PW(PW)) dut (
        .clk_fpga   (clk_fpga),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .tick_out   (tick_out),
        .base_tick  (base_tick),
        .sq_out     (sq_out)
    );

    always #5 clk_fpga = ~clk_fpga;

    int     n_checks = 0;
    int     n_errors = 0;
    longint e;
    bit     m_run [N];
    int     m_per [N];
    bit     m_os  [N];
    longint m_dl  [N];
    bit     m_sq  [N];
    bit     m_tick[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    // Edge index at which the per-th base tick strictly after edge ev is consumed.
    // base_tick is high after edges k*P, so it is seen by the logic at edges k*P+1.
    function automatic longint deadline(input longint ev, input int per);
        return ((((ev - 1) / P) + 1) + per - 1) * P + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_per[i] = 0; m_os[i] = 0; m_dl[i] = 0; m_sq[i] = 0; m_tick[i] = 0;
        end
        e = 0;
    endtask

    task automatic model_edge();
        bit hit;
        if (cfg_we) begin
            m_per[cfg_ch] = int'(cfg_period);
            m_os[cfg_ch]  = cfg_oneshot;
        end
        for (int i = 0; i < N; i++) begin
            hit = cfg_we && (int'(cfg_ch) == i);
            m_tick[i] = 0;
            if (stop[i]) begin
                m_run[i] = 0;
            end else if (start[i]) begin
                m_run[i] = (m_per[i] != 0);
                if (m_run[i]) m_dl[i] = deadline(e, m_per[i]);
            end else if (m_run[i]) begin
                if (hit) begin
                    m_run[i] = (m_per[i] != 0);
                    if (m_run[i]) m_dl[i] = deadline(e, m_per[i]);
                end else if (e == m_dl[i]) begin
                    m_tick[i] = 1;
                    if (m_os[i]) m_run[i] = 0;
                    else m_dl[i] = deadline(e, m_per[i]);
                end
            end
            if (!m_run[i]) m_sq[i] = 0;
            else if (m_tick[i]) m_sq[i] = ~m_sq[i];
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eb, et, es;
        for (int i = 0; i < N; i++) begin
            eb[i] = m_run[i];
            et[i] = m_tick[i];
`ifdef TICK_SCHED_SQUARE_EN
            es[i] = m_sq[i];
`else
            es[i] = 1'b0;
`endif
        end
        chk("busy",      32'(busy),      32'(eb));
        chk("tick_out",  32'(tick_out),  32'(et));
        chk("base_tick", 32'(base_tick), 32'((e % P) == 0));
        chk("sq_out",    32'(sq_out),    32'(es));
    endtask

    task automatic clear_inputs();
        cfg_we = 0; cfg_ch = '0; cfg_period = '0; cfg_oneshot = 0; start = '0; stop = '0;
    endtask

    task automatic cyc();
        @(posedge clk_fpga);
        e++;
        model_edge();
        #1;
        check_outputs();
        clear_inputs();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic cfg(input int ch, input int per, input bit os);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = PW'(per); cfg_oneshot = os;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        clear_inputs();
        #1;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_tick",  32'(tick_out),  32'd0);
        chk("rst_base",  32'(base_tick), 32'd0);
        chk("rst_sq",    32'(sq_out),    32'd0);
        model_reset();
        @(posedge clk_fpga);
        @(posedge clk_fpga);
        #3 rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst_n = 0;
        #2;
        apply_reset();
        run(12);

        cfg(0, 3, 0); cyc();
        start[0] = 1; cyc();
        run(40);
        stop[0] = 1; cyc();
        run(20);

        cfg(1, 2, 1); cyc();
        start[1] = 1; cyc();
        run(20);

        start[2] = 1; cyc();
        run(3);
        cfg(2, 5, 0); cyc();
        start[2] = 1; cyc();
        run(8);
        cfg(2, 2, 0); cyc();
        run(16);
        stop[2] = 1; cyc();

        cfg(3, 4, 0); cyc();
        start[3] = 1; stop[3] = 1; cyc();
        cfg(3, 1, 0); start[3] = 1; cyc();
        run(16);
        apply_reset();
        run(6);

        cfg(0, 1, 0); cyc();
        start[0] = 1; cyc();
        run(16);
        stop[0] = 1; cyc();
        run(4);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N; i++) begin
                start[i] = ($urandom_range(0, 29) == 0);
                stop[i]  = ($urandom_range(0, 59) == 0);
            end
            cyc();
            if (k == 1500) apply_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
